// File: rtl/sap_pkg.sv
// Shared constants for the SAP controller-sequencer and datapath.
// Holds opcode encodings, one-hot T-state bit indices and the bit
// positions of each control line inside the packed control word.
package sap_pkg;

   // Opcode encodings (low 4 bits of the IR opcode field).
   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_STA = 4'h3;
   localparam logic [3:0] OP_LDI = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Bit index of each T-state in the one-hot t_state vector.
   localparam int unsigned T1_IDX = 0;
   localparam int unsigned T2_IDX = 1;
   localparam int unsigned T3_IDX = 2;
   localparam int unsigned T4_IDX = 3;
   localparam int unsigned T5_IDX = 4;
   localparam int unsigned T6_IDX = 5;

   // Control-word bit positions.
   localparam int unsigned CW_CP = 0;
   localparam int unsigned CW_EP = 1;
   localparam int unsigned CW_LP = 2;
   localparam int unsigned CW_LM = 3;
   localparam int unsigned CW_CE = 4;
   localparam int unsigned CW_WE = 5;
   localparam int unsigned CW_LI = 6;
   localparam int unsigned CW_EI = 7;
   localparam int unsigned CW_LA = 8;
   localparam int unsigned CW_EA = 9;
   localparam int unsigned CW_SU = 10;
   localparam int unsigned CW_EU = 11;
   localparam int unsigned CW_LB = 12;
   localparam int unsigned CW_LO = 13;
   localparam int unsigned CW_W  = 14;

   typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring counter.
// Ports:
//   clk, clr_n   clock and asynchronous active-low reset (reset -> T1)
//   advance      move one state this cycle
//   early_ret    current state is the instruction's last; next advance goes to T1
//   t_state      one-hot current state, bit 0 = T1
//   wrap         this cycle's edge returns the ring to T1
module sap_ring_counter #(
   parameter int unsigned NUM_T = 6
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             advance,
   input  logic             early_ret,
   output logic [NUM_T-1:0] t_state,
   output logic             wrap
);

   localparam logic [NUM_T-1:0] T_FIRST = {{(NUM_T-1){1'b0}}, 1'b1};

   logic [NUM_T-1:0] t_q, t_d;

   assign wrap = advance & (early_ret | t_q[NUM_T-1]);

   always_comb begin
      t_d = t_q;
      if (wrap) begin
         t_d = T_FIRST;
      end else if (advance) begin
         t_d = {t_q[NUM_T-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         t_q <= T_FIRST;
      end else begin
         t_q <= t_d;
      end
   end

   assign t_state = t_q;

endmodule

// File: rtl/sap_ctrl_seq.sv
// SAP controller-sequencer: one-hot T-state sequencer plus instruction
// decoder producing the control word, halt latch and retired counter.
// Ports:
//   clk, clr_n                 clock, asynchronous active-low reset
//   opcode                     IR opcode field (upper bits must be 0)
//   zero_flag, carry_flag      registered ALU flags for JZ/JC
//   step_mode, step_req        single-step enable and advance pulse
//   cp..lo                     active-high control lines
//   t_state                    one-hot current T-state
//   halted                     HLT executed
//   instr_count                retired instructions (wraps)
module sap_ctrl_seq
   import sap_pkg::*;
#(
   parameter int unsigned OPC_W     = 4,
   parameter int unsigned NUM_T     = 6,
   parameter int unsigned EARLY_END = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [OPC_W-1:0] opcode,
   input  logic             zero_flag,
   input  logic             carry_flag,
   input  logic             step_mode,
   input  logic             step_req,
   output logic             cp,
   output logic             ep,
   output logic             lp,
   output logic             lm,
   output logic             ce,
   output logic             we,
   output logic             li,
   output logic             ei,
   output logic             la,
   output logic             ea,
   output logic             su,
   output logic             eu,
   output logic             lb,
   output logic             lo,
   output logic [NUM_T-1:0] t_state,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   logic             op_ok;
   logic [3:0]       op;
   logic             go, hlt_t4, advance, at_last, early_ret, wrap;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_word_t       cw;

   // Non-zero upper opcode bits turn the instruction into a NOP.
   assign op_ok = ((opcode >> 4) == '0);
   assign op    = opcode[3:0];
   assign go    = step_mode ? step_req : 1'b1;

   // HLT must not leave T4: the halting edge sets halted instead of advancing.
   assign hlt_t4  = t_state[T4_IDX] & op_ok & (op == OP_HLT);
   assign advance = go & ~halted_q & ~hlt_t4;

   always_comb begin
      at_last = t_state[T4_IDX];
      if (op_ok) begin
         case (op)
            OP_ADD, OP_SUB: at_last = t_state[T6_IDX];
            OP_LDA, OP_STA: at_last = t_state[T5_IDX];
            default:        at_last = t_state[T4_IDX];
         endcase
      end
   end

   assign early_ret = (EARLY_END != 0) & at_last;

   sap_ring_counter #(
      .NUM_T (NUM_T)
   ) u_ring (
      .clk       (clk),
      .clr_n     (clr_n),
      .advance   (advance),
      .early_ret (early_ret),
      .t_state   (t_state),
      .wrap      (wrap)
   );

   always_comb begin
      halted_d = halted_q | (go & hlt_t4);
      cnt_d    = wrap ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end

   // Control decode; clr_n gates it so the word is quiet during reset.
   always_comb begin
      cw = '0;
      if (clr_n && !halted_q) begin
         if (t_state[T1_IDX]) begin
            cw[CW_EP] = 1'b1;
            cw[CW_LM] = 1'b1;
         end
         if (t_state[T2_IDX]) cw[CW_CP] = 1'b1;
         if (t_state[T3_IDX]) begin
            cw[CW_CE] = 1'b1;
            cw[CW_LI] = 1'b1;
         end
         if (t_state[T4_IDX] && op_ok) begin
            case (op)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  cw[CW_EI] = 1'b1;
                  cw[CW_LM] = 1'b1;
               end
               OP_LDI: begin
                  cw[CW_EI] = 1'b1;
                  cw[CW_LA] = 1'b1;
               end
               OP_JMP: begin
                  cw[CW_EI] = 1'b1;
                  cw[CW_LP] = 1'b1;
               end
               OP_JZ: begin
                  cw[CW_EI] = zero_flag;
                  cw[CW_LP] = zero_flag;
               end
               OP_JC: begin
                  cw[CW_EI] = carry_flag;
                  cw[CW_LP] = carry_flag;
               end
               OP_OUT: begin
                  cw[CW_EA] = 1'b1;
                  cw[CW_LO] = 1'b1;
               end
               default: ;
            endcase
         end
         if (t_state[T5_IDX] && op_ok) begin
            case (op)
               OP_LDA: begin
                  cw[CW_CE] = 1'b1;
                  cw[CW_LA] = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  cw[CW_CE] = 1'b1;
                  cw[CW_LB] = 1'b1;
               end
               OP_STA: begin
                  cw[CW_EA] = 1'b1;
                  cw[CW_WE] = 1'b1;
               end
               default: ;
            endcase
         end
         if (t_state[T6_IDX] && op_ok && (op == OP_ADD || op == OP_SUB)) begin
            cw[CW_EU] = 1'b1;
            cw[CW_LA] = 1'b1;
            cw[CW_SU] = (op == OP_SUB);
         end
      end
   end

   assign cp          = cw[CW_CP];
   assign ep          = cw[CW_EP];
   assign lp          = cw[CW_LP];
   assign lm          = cw[CW_LM];
   assign ce          = cw[CW_CE];
   assign we          = cw[CW_WE];
   assign li          = cw[CW_LI];
   assign ei          = cw[CW_EI];
   assign la          = cw[CW_LA];
   assign ea          = cw[CW_EA];
   assign su          = cw[CW_SU];
   assign eu          = cw[CW_EU];
   assign lb          = cw[CW_LB];
   assign lo          = cw[CW_LO];
   assign halted      = halted_q;
   assign instr_count = cnt_q;

endmodule

// File: doc/sap_ctrl_seq.md
Name: sap_ctrl_seq

Overview:
Parametrised controller-sequencer for the next-generation SAP core. It replaces the fixed six-state ring counter and hard-wired decoder with a one-hot T-state sequencer of configurable depth, and drives the control word to PC, MAR, RAM, IR, accumulator, ALU, register B and output register. Beyond the SAP-1 set (LDA/ADD/SUB/OUT/HLT) it adds STA, LDI, JMP, JZ and JC, optional early termination of short instructions, single-step mode and a retired-instruction counter.

Parameters:
OPC_W, 4, opcode width; only the low 4 bits are decoded, upper bits must be 0 or the instruction is treated as NOP.
NUM_T, 6, T-states per machine cycle; legal 6..8; states above T6 are idle padding.
EARLY_END, 1, 1 = return to T1 right after an instruction's last active T-state; 0 = always run NUM_T states.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state changes on the rising edge
clr_n  in  1  asynchronous active-low reset
opcode  in  OPC_W  opcode field from the instruction register, valid from T4
zero_flag  in  1  registered accumulator==0 flag
carry_flag  in  1  registered ALU carry flag
step_mode  in  1  1 = single-step
step_req  in  1  already-synchronised one-cycle advance pulse, used only in step mode
cp  out  1  PC increment
ep  out  1  PC drives bus
lp  out  1  PC load from bus (jumps)
lm  out  1  MAR load
ce  out  1  RAM drives bus
we  out  1  RAM write from bus
li  out  1  IR load
ei  out  1  IR address field drives bus
la  out  1  accumulator load
ea  out  1  accumulator drives bus
su  out  1  ALU subtract
eu  out  1  ALU drives bus
lb  out  1  register B load
lo  out  1  output register load
t_state  out  NUM_T  one-hot current T-state
halted  out  1  HLT executed
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (clr_n low, asynchronous): t_state = T1 (bit 0), halted = 0, instr_count = 0. The whole control word decodes to 0 while clr_n is low. Reset in mid-instruction abandons that instruction; the counter does not count it.
- All control outputs are active-high and combinational from the registered t_state and opcode; at most one bus driver (ep/ce/ei/ea/eu) is high in any state.
- Advance: normal mode moves one state per clock. In step mode the sequencer moves only in a cycle with step_req = 1; outputs hold steady between steps.
- Fetch for all opcodes:
  - T1: ep, lm
  - T2: cp
  - T3: ce, li
- Execute:
  - LDA 0000: T4 ei,lm; T5 ce,la
  - ADD 0001: T4 ei,lm; T5 ce,lb; T6 eu,la
  - SUB 0010: as ADD, with su held high in T6
  - STA 0011: T4 ei,lm; T5 ea,we
  - LDI 0100: T4 ei,la (4-bit immediate, zero-extended on the bus)
  - JMP 0101: T4 ei,lp
  - JZ 0110: T4 ei,lp only if zero_flag=1, sampled during T4
  - JC 0111: T4 ei,lp only if carry_flag=1, sampled during T4
  - OUT 1110: T4 ea,lo
  - HLT 1111: T4 no controls; halted is set at the T4 edge
  - All other opcodes: NOP, no controls
- Last active state: T6 for ADD/SUB; T5 for LDA/STA; T4 for all others, including a not-taken jump and NOP.
- EARLY_END=1: from the last active state the next state is T1. EARLY_END=0: the sequencer runs to T(NUM_T) with idle states, then returns to T1.
- instr_count increments on the edge that returns the sequencer to T1.
- Halt: once halted=1, t_state freezes at T4, the control word is 0 and step_req is ignored. Only clr_n clears it. HLT does not increment instr_count.

Decomposition:
- Package sap_pkg holds the opcode localparams (OP_LDA..OP_HLT), the T-state index constants and the control-word bit-position constants, shared with the datapath.
- One natural sub-module: sap_ring_counter, the parametrised one-hot ring with advance enable, early-return input and asynchronous clr_n.

Test Plan:
1. Reset, then opcode=0000, EARLY_END=1 -> t_state 000001,000010,000100,001000,010000,000001; ce&la in T5; instr_count=1.
2. ADD (0001) with EARLY_END=0, NUM_T=8 -> eu&la in T6; T7 and T8 have all controls 0; T1 follows T8; instr_count increments only at the T8->T1 edge.
3. JZ (0110): zero_flag=1 -> ei&lp in T4. zero_flag=0 -> lp=0 and T1 follows T4.
4. Step mode with step_req pulsed every 5 cycles -> exactly one state advance per pulse; t_state unchanged between pulses.
5. HLT (1111) after three LDI -> halted=1, t_state stuck at 001000 for 50 cycles, control word 0, instr_count=3. clr_n low -> T1, halted=0, count=0.
6. clr_n asserted asynchronously mid-T5 of SUB -> outputs 0 within the same cycle; after release, T1 fetch, instr_count=0.
